// File: rtl/opnd_fetch_seq.sv
// -----------------------------------------------------------------------------
// opnd_fetch_seq
//
// Read-side operand sequencer for the latch register file. Fetches rs1 and rs2
// one per cycle through a single shared combinational read port, then presents
// both operands to execute over a valid/ready handshake.
//
// Optional feature (macro OPFETCH_FWD_EN):
//   When defined, the writeback bus is snooped. A read that coincides with a
//   writeback to the same register takes wb_result. Captured operands are kept
//   current by later writebacks until execute consumes them.
//   When undefined, operands are plain snapshots of rf_data and wb_* is ignored.
//
// Ports:
//   clk        in   clock, rising edge
//   a_reset_n  in   synchronous active-low reset
//   req_valid  in   decode request valid
//   req_ready  out  request accepted this cycle (low while in reset)
//   req_addr1  in   rs1 index
//   req_addr2  in   rs2 index
//   req_use1   in   instruction reads rs1
//   req_use2   in   instruction reads rs2
//   rf_addr    out  shared regfile read address (0 when not reading)
//   rf_data    in   regfile read data, combinational from rf_addr
//   wb_en      in   writeback valid
//   wb_rd      in   writeback destination
//   wb_result  in   writeback data
//   op_valid   out  operands valid for execute
//   op_ready   in   execute consumes operands
//   op_rs1     out  operand 1
//   op_rs2     out  operand 2
// -----------------------------------------------------------------------------
module opnd_fetch_seq #(
    parameter int W        = 32,
    parameter int R        = 5,
    parameter int NUM_REGS = 32
) (
    input  logic         clk,
    input  logic         a_reset_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [R-1:0] req_addr1,
    input  logic [R-1:0] req_addr2,
    input  logic         req_use1,
    input  logic         req_use2,
    output logic [R-1:0] rf_addr,
    input  logic [W-1:0] rf_data,
    input  logic         wb_en,
    input  logic [R-1:0] wb_rd,
    input  logic [W-1:0] wb_result,
    output logic         op_valid,
    input  logic         op_ready,
    output logic [W-1:0] op_rs1,
    output logic [W-1:0] op_rs2
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD1  = 2'd1;
    localparam logic [1:0] ST_RD2  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // One bit wider than an address so NUM_REGS == 2**R still fits.
    localparam logic [R:0] NUM_REGS_L = NUM_REGS[R:0];

    logic [1:0] state_reg;
    logic [1:0] state_next;
    logic [1:0] accept_target;
    logic       accept;
    logic       addr_ok;
    logic       fwd_cap;
    logic [W-1:0] rd_value;

    // Per-operand views; index 0 is rs1, index 1 is rs2.
    logic [1:0][R-1:0] req_addr_pk;
    logic [1:0]        req_use_pk;
    logic [1:0][R-1:0] slot_addr;
    logic [1:0]        slot_use;
    logic [1:0][W-1:0] slot_op;

    assign req_addr_pk = {req_addr2, req_addr1};
    assign req_use_pk  = {req_use2, req_use1};

    assign req_ready = a_reset_n &&
                       ((state_reg == ST_IDLE) || ((state_reg == ST_DONE) && op_ready));
    assign accept    = req_valid && req_ready;
    assign op_valid  = (state_reg == ST_DONE);
    assign op_rs1    = slot_op[0];
    assign op_rs2    = slot_op[1];

    // First state after an accept skips operands the instruction does not read.
    assign accept_target = req_use1 ? ST_RD1 : (req_use2 ? ST_RD2 : ST_DONE);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept) state_next = accept_target;
            ST_RD1:  state_next = slot_use[1] ? ST_RD2 : ST_DONE;
            ST_RD2:  state_next = ST_DONE;
            ST_DONE: if (op_ready) state_next = accept ? accept_target : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!a_reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Read address is parked at 0 outside the read states so the port does not toggle.
    always_comb begin
        rf_addr = '0;
        case (state_reg)
            ST_RD1:  rf_addr = slot_addr[0];
            ST_RD2:  rf_addr = slot_addr[1];
            default: rf_addr = '0;
        endcase
    end

    // x0 and any index beyond the architectural file read as zero.
    assign addr_ok = (rf_addr != '0) && ({1'b0, rf_addr} < NUM_REGS_L);

`ifdef OPFETCH_FWD_EN
    assign fwd_cap = wb_en && (wb_rd == rf_addr);
`else
    assign fwd_cap = 1'b0;
    logic unused_wb;
    assign unused_wb = ^{wb_en, wb_rd, wb_result};
`endif

    assign rd_value = !addr_ok ? '0 : (fwd_cap ? wb_result : rf_data);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            localparam logic [1:0] CAP_ST = (gi == 0) ? ST_RD1 : ST_RD2;

            logic [R-1:0] addr_reg;
            logic         use_reg;
            logic [W-1:0] op_reg;
            logic         holding;
            logic         wb_hit;

            // Operand already captured and not yet handed to execute. rs1 is
            // already held while rs2 is being read.
            assign holding = ((state_reg == ST_DONE) && !op_ready) ||
                             ((gi == 0) && (state_reg == ST_RD2));

`ifdef OPFETCH_FWD_EN
            assign wb_hit = wb_en && use_reg && (addr_reg != '0) && (wb_rd == addr_reg);
`else
            assign wb_hit = 1'b0;
`endif

            always_ff @(posedge clk) begin
                if (!a_reset_n) begin
                    addr_reg <= '0;
                    use_reg  <= 1'b0;
                    op_reg   <= '0;
                end else if (accept) begin
                    // Clearing here is what makes a skipped operand read as 0.
                    addr_reg <= req_addr_pk[gi];
                    use_reg  <= req_use_pk[gi];
                    op_reg   <= '0;
                end else if (state_reg == CAP_ST) begin
                    op_reg <= rd_value;
                end else if (holding && wb_hit) begin
                    op_reg <= wb_result;
                end
            end

            assign slot_addr[gi] = addr_reg;
            assign slot_use[gi]  = use_reg;
            assign slot_op[gi]   = op_reg;
        end
    endgenerate

endmodule

// File: tb/tb_opnd_fetch_seq.sv
module tb_opnd_fetch_seq;

    logic        clk;
    logic        a_reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_addr1;
    logic [4:0]  req_addr2;
    logic        req_use1;
    logic        req_use2;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result;
    logic        op_valid;
    logic        op_ready;
    logic [31:0] op_rs1;
    logic [31:0] op_rs2;

    logic [31:0] rf_mem [32];
    int tests_run;
    int tests_failed;

    assign rf_data = rf_mem[rf_addr];

    opnd_fetch_seq #(.W(32), .R(5), .NUM_REGS(32)) dut (
        .clk       (clk),
        .a_reset_n (a_reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr1 (req_addr1),
        .req_addr2 (req_addr2),
        .req_use1  (req_use1),
        .req_use2  (req_use2),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data),
        .wb_en     (wb_en),
        .wb_rd     (wb_rd),
        .wb_result (wb_result),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_rs1    (op_rs1),
        .op_rs2    (op_rs2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%08h", tag, got);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_req(input logic [4:0] a1, input logic [4:0] a2,
                           input logic u1, input logic u2);
        req_valid = 1'b1;
        req_addr1 = a1;
        req_addr2 = a2;
        req_use1  = u1;
        req_use2  = u2;
    endtask

    logic [31:0] exp_fwd_rs1;
    logic [31:0] exp_fwd_rs2;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
`ifdef OPFETCH_FWD_EN
        exp_fwd_rs1 = 32'h0000_DEAD;
        exp_fwd_rs2 = 32'h0000_5555;
`else
        exp_fwd_rs1 = 32'h0000_7777;
        exp_fwd_rs2 = 32'h0000_ABCD;
`endif
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'h0100_0000 + i;
        rf_mem[0]  = 32'hFFFF_FFFF;   // x0 must still read as 0
        rf_mem[5]  = 32'h0000_1234;
        rf_mem[6]  = 32'h0000_ABCD;
        rf_mem[7]  = 32'h0000_7777;
        rf_mem[9]  = 32'h0000_9999;
        rf_mem[10] = 32'h1111_0000;
        rf_mem[11] = 32'h2222_0000;
        rf_mem[12] = 32'h3333_0000;

        a_reset_n = 1'b0;
        op_ready  = 1'b0;
        wb_en     = 1'b0;
        wb_rd     = '0;
        wb_result = '0;
        set_req(5'd5, 5'd6, 1'b1, 1'b1);

        // 1: reset with a request pending
        next_cycle(); next_cycle(); mid();
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_op_valid",  {31'd0, op_valid},  32'd0);
        check("rst_op_rs1",    op_rs1,             32'd0);
        check("rst_op_rs2",    op_rs2,             32'd0);
        check("rst_rf_addr",   {27'd0, rf_addr},   32'd0);

        // 2: two-operand fetch, 3-cycle latency
        next_cycle(); a_reset_n = 1'b1; req_valid = 1'b0; mid();
        check("idle_req_ready", {31'd0, req_ready}, 32'd1);
        next_cycle(); set_req(5'd5, 5'd6, 1'b1, 1'b1); mid();
        check("t2_req_ready", {31'd0, req_ready}, 32'd1);
        next_cycle(); req_valid = 1'b0; mid();
        check("t2_c1_rf_addr",  {27'd0, rf_addr},  32'd5);
        check("t2_c1_op_valid", {31'd0, op_valid}, 32'd0);
        next_cycle(); mid();
        check("t2_c2_rf_addr",  {27'd0, rf_addr},  32'd6);
        check("t2_c2_op_valid", {31'd0, op_valid}, 32'd0);
        next_cycle(); mid();
        check("t2_c3_op_valid", {31'd0, op_valid}, 32'd1);
        check("t2_op_rs1",      op_rs1,            32'h0000_1234);
        check("t2_op_rs2",      op_rs2,            32'h0000_ABCD);
        check("t2_done_rf_addr", {27'd0, rf_addr}, 32'd0);
        next_cycle(); op_ready = 1'b1; mid();
        next_cycle(); op_ready = 1'b0;

        // 3: rs2 only, addr2 = x0, 2-cycle latency
        set_req(5'd9, 5'd0, 1'b0, 1'b1); mid();
        check("t3_after_consume_op_valid", {31'd0, op_valid}, 32'd0);
        next_cycle(); req_valid = 1'b0; mid();
        check("t3_c1_op_valid", {31'd0, op_valid}, 32'd0);
        check("t3_c1_rf_addr",  {27'd0, rf_addr},  32'd0);
        next_cycle(); mid();
        check("t3_c2_op_valid", {31'd0, op_valid}, 32'd1);
        check("t3_op_rs1",      op_rs1,            32'd0);
        check("t3_op_rs2",      op_rs2,            32'd0);
        next_cycle(); op_ready = 1'b1; mid();
        next_cycle(); op_ready = 1'b0;

        // 4: hold under backpressure, then accept in the same cycle as the handshake
        set_req(5'd10, 5'd11, 1'b1, 1'b1); mid();
        next_cycle(); req_valid = 1'b0; mid();
        next_cycle(); mid();
        next_cycle(); set_req(5'd12, 5'd13, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            mid();
            check("t4_hold_op_valid",  {31'd0, op_valid},  32'd1);
            check("t4_hold_req_ready", {31'd0, req_ready}, 32'd0);
            check("t4_hold_op_rs1",    op_rs1,             32'h1111_0000);
            check("t4_hold_op_rs2",    op_rs2,             32'h2222_0000);
            if (k == 1) rf_mem[10] = 32'hBAD0_0000;
            next_cycle();
        end
        op_ready = 1'b1; mid();
        check("t4_ready_req_ready", {31'd0, req_ready}, 32'd1);
        next_cycle(); op_ready = 1'b0; req_valid = 1'b0; mid();
        check("t4_new_op_valid", {31'd0, op_valid}, 32'd0);
        check("t4_new_rf_addr",  {27'd0, rf_addr},  32'd12);
        next_cycle(); mid();
        check("t4_new_op_valid2", {31'd0, op_valid}, 32'd1);
        check("t4_new_op_rs1",    op_rs1,            32'h3333_0000);
        check("t4_new_op_rs2",    op_rs2,            32'd0);
        next_cycle(); op_ready = 1'b1; mid();
        next_cycle(); op_ready = 1'b0;

        // 5: writeback snooping (expected values depend on the build)
        set_req(5'd7, 5'd6, 1'b1, 1'b1); mid();
        next_cycle(); req_valid = 1'b0;
        wb_en = 1'b1; wb_rd = 5'd7; wb_result = 32'h0000_DEAD; mid();
        check("t5_rd1_rf_addr", {27'd0, rf_addr}, 32'd7);
        next_cycle(); wb_en = 1'b0; mid();
        check("t5_rd2_op_rs1", op_rs1, exp_fwd_rs1);
        next_cycle(); wb_en = 1'b1; wb_rd = 5'd6; wb_result = 32'h0000_5555; mid();
        check("t5_done_op_valid", {31'd0, op_valid}, 32'd1);
        check("t5_done_op_rs2",   op_rs2,            32'h0000_ABCD);
        next_cycle(); wb_en = 1'b0; mid();
        check("t5_upd_op_rs2", op_rs2, exp_fwd_rs2);
        check("t5_upd_op_rs1", op_rs1, exp_fwd_rs1);
        next_cycle(); op_ready = 1'b1; mid();
        next_cycle(); op_ready = 1'b0;

        // 6: reset in RD2 aborts the fetch
        set_req(5'd5, 5'd6, 1'b1, 1'b1); mid();
        next_cycle(); req_valid = 1'b0; mid();
        next_cycle(); a_reset_n = 1'b0; mid();
        check("t6_rd2_rf_addr",  {27'd0, rf_addr},   32'd6);
        check("t6_rst_req_ready", {31'd0, req_ready}, 32'd0);
        next_cycle(); a_reset_n = 1'b1; mid();
        check("t6_op_valid",   {31'd0, op_valid},  32'd0);
        check("t6_op_rs1",     op_rs1,             32'd0);
        check("t6_op_rs2",     op_rs2,             32'd0);
        check("t6_req_ready",  {31'd0, req_ready}, 32'd1);
        check("t6_rf_addr",    {27'd0, rf_addr},   32'd0);
        for (int k = 0; k < 3; k++) begin
            next_cycle(); mid();
            check("t6_idle_op_valid", {31'd0, op_valid}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
